// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator.
// Holds the fetch PC, advances it on every accepted fetch (req_o & gnt_i) and
// redirects it on a trap or an EX-stage branch, traps taking priority.
// Reaching END_ADDR either wraps to START_ADDR or halts, depending on WRAP_EN.
// A misaligned redirect target halts the generator until an aligned redirect.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   enable_i, stall_i     fetch enable / fetch-stage stall
//   trap_flag_i/addr_i    trap redirect request and target
//   br_flag_i/addr_i      EX branch/jump taken and target
//   gnt_i                 bus accepted the current fetch request
//   pc_o                  current fetch PC
//   req_o                 fetch request valid (combinational)
//   redirect_o            one-cycle pulse after a redirect (flush if_id)
//   misalign_o            sticky flag: last redirect target misaligned
//   halt_o                generator is halted
//   fetch_cnt_o           number of accepted fetches (wraps)
module pc_gen #(
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  START_ADDR = 32'h0000_0000,
  parameter logic [ADDR_W-1:0]  END_ADDR   = 32'h0000_3FFC,
  parameter int unsigned        STEP       = 4,
  parameter bit                 WRAP_EN    = 1'b1,
  parameter int unsigned        CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              stall_i,
  input  logic              trap_flag_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              br_flag_i,
  input  logic [ADDR_W-1:0] br_addr_i,
  input  logic              gnt_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              req_o,
  output logic              redirect_o,
  output logic              misalign_o,
  output logic              halt_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              redirect_q, redirect_d;
  logic              misalign_q, misalign_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              xfer;
  logic              redir;
  logic [ADDR_W-1:0] target;

  assign req_o  = (state_q == StRun) & enable_i & ~stall_i;
  assign xfer   = req_o & gnt_i;
  assign redir  = trap_flag_i | br_flag_i;
  assign target = trap_flag_i ? trap_addr_i : br_addr_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    misalign_d = misalign_q;
    // A transfer coincident with a redirect still counts; redirect_o flushes it.
    cnt_d      = cnt_q + CNT_W'(xfer);

    if (redir) begin
      // Redirects ignore stall/enable/gnt/state so a stall never loses one.
      pc_d       = target;
      redirect_d = 1'b1;
      if (target[1:0] != 2'b00) begin
        misalign_d = 1'b1;
        state_d    = StHalt;
      end else begin
        misalign_d = 1'b0;
        state_d    = StRun;
      end
    end else if (xfer) begin
      if (pc_q < END_ADDR) begin
        pc_d = pc_q + ADDR_W'(STEP);
      end else if (WRAP_EN) begin
        pc_d = START_ADDR;
      end else begin
        state_d = StHalt;
      end
    end else if (state_q == StBoot) begin
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= START_ADDR;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_o        = pc_q;
  assign redirect_o  = redirect_q;
  assign misalign_o  = misalign_q;
  assign halt_o      = (state_q == StHalt);
  assign fetch_cnt_o = cnt_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the yadan core fetch stage. It holds the fetch PC, advances it on each accepted fetch, and redirects it on a trap or an EX-stage branch, with traps taking priority. It adds a fetch request/grant handshake toward cpu_ahb_if, configurable wrap/halt at the end of instruction memory, misaligned-target detection, and an accepted-fetch counter. It sits between ctrl/ex/mem and if_id / cpu_ahb_if.

## Interface
Parameters:
- ADDR_W, 32, PC and target address width
- START_ADDR, 32'h0000_0000, reset PC and wrap target
- END_ADDR, 32'h0000_3FFC, last valid fetch address
- STEP, 4, PC increment per accepted fetch
- WRAP_EN, 1, 1: wrap to START_ADDR after END_ADDR; 0: halt after END_ADDR
- CNT_W, 32, fetch counter width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable_i  in  1  fetch enable from mem (PCchange enable)
- stall_i  in  1  fetch-stage stall from ctrl (1 = stall)
- trap_flag_i  in  1  trap/exception redirect request
- trap_addr_i  in  ADDR_W  trap target
- br_flag_i  in  1  EX branch/jump taken
- br_addr_i  in  ADDR_W  branch target
- gnt_i  in  1  bus accepted the current fetch request
- pc_o  out  ADDR_W  current fetch PC
- req_o  out  1  fetch request valid
- redirect_o  out  1  one-cycle pulse: PC was redirected (flush if_id)
- misalign_o  out  1  sticky: last redirect target had addr[1:0] != 0
- halt_o  out  1  generator in HALT state
- fetch_cnt_o  out  CNT_W  count of accepted fetches

## Operation
- States: BOOT, RUN, HALT. State and all outputs are registered except req_o.
- req_o = (state == RUN) & enable_i & ~stall_i. Transfer = req_o & gnt_i.
- Redirect selection per cycle: trap_flag_i > br_flag_i. The selected target is taken regardless of stall_i, enable_i, gnt_i or state (a stall never loses a redirect).
- On redirect: pc_o <= target; redirect_o <= 1 next cycle; if target[1:0] != 0: misalign_o <= 1, state -> HALT; else misalign_o <= 0, state -> RUN (including from HALT and BOOT).
- No redirect, transfer: if pc_o < END_ADDR, pc_o <= pc_o + STEP (mod 2^ADDR_W). If pc_o >= END_ADDR: WRAP_EN=1 -> pc_o <= START_ADDR; WRAP_EN=0 -> pc_o held, state -> HALT, halt_o <= 1.
- No redirect, no transfer: pc_o held.
- fetch_cnt_o increments on every transfer, including one coincident with a redirect (the wrong-path fetch is flushed by redirect_o). Wraps modulo 2^CNT_W.
- BOOT -> RUN unconditionally after one cycle, unless a redirect occurs (handled as above).
- HALT is left only by a redirect with an aligned target.

## Timing
- Reset values: pc_o = START_ADDR, state BOOT, req_o = 0, redirect_o = 0, misalign_o = 0, halt_o = 0, fetch_cnt_o = 0.
- First req_o possible in the second cycle after reset deassertion.
- Redirect asserted in cycle N -> pc_o = target and redirect_o = 1 in cycle N+1. redirect_o is low in N+2 unless another redirect occurs.
- Transfer in cycle N -> new pc_o and incremented fetch_cnt_o in N+1. Back-to-back transfers sustain one per cycle.
- Trap and branch in the same cycle -> trap target only. A single redirect_o pulse.
- Reset asserted mid-operation -> all outputs return to reset values immediately (asynchronous). Any pending redirect is discarded.

## Test plan
- Reset, enable_i=1, gnt_i=1 held -> BOOT one cycle, then pc_o 0x0, 0x4, 0x8...; fetch_cnt_o = 3 after three grants.
- stall_i=1 for 3 cycles with br_flag_i=1, br_addr_i=0x100 in the first stall cycle -> pc_o = 0x100 next cycle, redirect_o single pulse, req_o low until the stall ends.
- trap_flag_i and br_flag_i together (0x200 vs 0x300) -> pc_o = 0x200, one redirect_o pulse.
- WRAP_EN=1, pc_o = 0x3FFC, transfer -> pc_o = 0x0. WRAP_EN=0 -> pc_o stays 0x3FFC, halt_o = 1, req_o = 0; branch to 0x40 -> RUN, pc_o = 0x40.
- Branch to 0x102 -> misalign_o = 1, halt_o = 1, req_o = 0; trap to 0x80 -> misalign_o = 0, RUN.
- rst_n pulsed low mid-stream at pc_o = 0x24 -> pc_o = 0x0 and fetch_cnt_o = 0 without waiting for a clock edge.
